// File: rtl/edge_det_pkg.sv
// Shared encodings for the edge event detector: edge-select modes and
// the arming state machine states.
package edge_det_pkg;

  // Edge-select encodings driven on the mode input.
  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } mode_e;

  // Arming FSM: ARMING suppresses detection until the synchroniser and
  // history register hold real samples; ACTIVE is held until reset.
  typedef enum logic {
    ARMING = 1'b0,
    ACTIVE = 1'b1
  } arm_state_e;

endpackage

// File: rtl/sync_chain_enable.sv
// Per-channel multi-stage synchroniser that only shifts on enabled cycles.
// Stage 0 samples the asynchronous input; q is the last stage.
module sync_chain_enable #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  // Shift chain: clear on reset, advance one stage per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/edge_event_detector.sv
// Multi-channel edge event detector: synchronises inputs, detects edges
// against a history register, emits one-cycle pulses, latches sticky flags
// and keeps a saturating event count. Detection is held off by an arming
// FSM until the synchroniser has filled after reset.
//
// Handshake: there is no valid/ready flow here. The enable e qualifies
// each clock edge: sampling, history and arming advance only when e=1,
// while clr, cnt_clr and reset act on every edge irrespective of e.
module edge_event_detector
  import edge_det_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] pulse,
  output logic [WIDTH-1:0] sticky,
  output logic             irq,
  output logic [CNT_W-1:0] count,
  output logic             armed
);

  localparam int PW    = $clog2(WIDTH + 1);
  localparam int SW    = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [SW-1:0]    CNT_MAX  = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  arm_state_e       state, state_next;
  logic [ARM_W-1:0] arm_cnt, arm_cnt_next;

  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] raw_event;
  logic [WIDTH-1:0] gated_event;
  logic [PW-1:0]    pop;
  logic [SW-1:0]    count_base;
  logic [SW-1:0]    count_sum;
  logic [CNT_W-1:0] count_next;

  sync_chain_enable #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .en    (e),
    .d     (d),
    .q     (q)
  );

  // Arming FSM state register and enabled-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARMING;
      arm_cnt <= '0;
    end else begin
      state   <= state_next;
      arm_cnt <= arm_cnt_next;
    end
  end

  // Arming FSM next state: leave ARMING on the (SYNC_STAGES+1)-th enabled cycle.
  always_comb begin
    state_next   = state;
    arm_cnt_next = arm_cnt;
    case (state)
      ARMING: begin
        if (e) begin
          if (arm_cnt == ARM_LAST) begin
            state_next   = ACTIVE;
            arm_cnt_next = '0;
          end else begin
            arm_cnt_next = arm_cnt + ARM_W'(1);
          end
        end
      end
      ACTIVE:  state_next = ACTIVE;
      default: state_next = ARMING;
    endcase
  end

  assign armed = (state == ACTIVE);

  // Raw edge detection on pre-update q and prev, selected by mode.
  always_comb begin
    raw_event = '0;
    case (mode)
      MODE_RISE: raw_event = q & ~prev;
      MODE_FALL: raw_event = ~q & prev;
      MODE_BOTH: raw_event = q ^ prev;
      MODE_NONE: raw_event = '0;
      default:   raw_event = '0;
    endcase
  end

  assign gated_event = (e && armed) ? raw_event : '0;

  // Population count of this cycle's gated events.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PW'(gated_event[i]);
    end
  end

  // Saturating counter update; cnt_clr replaces the old value with this cycle's events.
  always_comb begin
    count_base = cnt_clr ? '0 : SW'(count);
    count_sum  = count_base + SW'(pop);
    count_next = (count_sum > CNT_MAX) ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];
  end

  // History, pulse, sticky and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev   <= '0;
      pulse  <= '0;
      sticky <= '0;
      count  <= '0;
    end else begin
      if (e) begin
        prev <= q;
      end
      pulse  <= gated_event;
      sticky <= (sticky & ~clr) | gated_event;
      count  <= count_next;
    end
  end

  assign irq = |sticky;

endmodule
